// File: rtl/pre_hyp_cordic_ctrl.sv
// Sequencer for a range-extended hyperbolic CORDIC: issues PRE_ITER pre-atanh
// steps, then the standard indices 1..MAIN_ITER with 4 and 13 issued twice.
module pre_hyp_cordic_ctrl #(
    parameter int PRE_ITER  = 6,
    parameter int MAIN_ITER = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       iter_ready,
    output logic       load,
    output logic       iter_valid,
    output logic       pre_sel,
    output logic [5:0] lut_num,
    output logic [4:0] shift,
    output logic       rep,
    output logic       last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, PRE, MAIN, FIN} state_t;

    localparam logic [5:0] PreLast  = 6'(PRE_ITER - 1);
    localparam logic [5:0] MainLast = 6'(MAIN_ITER);

    // Indices 4 and 13 are issued twice for convergence of the hyperbolic rotation.
    function automatic logic is_rep(input logic [5:0] n);
        return (n == 6'd4 && MAIN_ITER >= 4) || (n == 6'd13 && MAIN_ITER >= 13);
    endfunction

    localparam logic FirstLast = (MAIN_ITER == 1) && !((MAIN_ITER >= 4) && (MAIN_ITER == 4));

    state_t     state_q;
    logic       valid_q, pre_sel_q, rep_q, last_q, busy_q, done_q;
    logic [5:0] lut_q;
    logic [4:0] shift_q;

    logic [5:0] lut_d;
    logic       rep_d, last_d, accept;

    assign accept = valid_q & iter_ready;

    // Next main-phase issue: repeat the current index once, otherwise advance.
    always_comb begin
        lut_d = lut_q + 6'd1;
        rep_d = 1'b0;
        if (is_rep(lut_q) && !rep_q) begin
            lut_d = lut_q;
            rep_d = 1'b1;
        end
        last_d = (lut_d == MainLast) && (rep_d || !is_rep(lut_d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            pre_sel_q <= 1'b0;
            lut_q     <= '0;
            shift_q   <= '0;
            rep_q     <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            pre_sel_q <= 1'b0;
            lut_q     <= '0;
            shift_q   <= '0;
            rep_q     <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= PRE;
                        valid_q   <= 1'b1;
                        pre_sel_q <= 1'b1;
                        lut_q     <= '0;
                        shift_q   <= 5'd2;
                        busy_q    <= 1'b1;
                    end
                end
                PRE: begin
                    if (accept) begin
                        if (lut_q == PreLast) begin
                            state_q   <= MAIN;
                            pre_sel_q <= 1'b0;
                            lut_q     <= 6'd1;
                            shift_q   <= 5'd1;
                            rep_q     <= 1'b0;
                            last_q    <= FirstLast;
                        end else begin
                            lut_q   <= lut_q + 6'd1;
                            shift_q <= shift_q + 5'd1;
                        end
                    end
                end
                MAIN: begin
                    if (accept) begin
                        if (last_q) begin
                            state_q <= FIN;
                            valid_q <= 1'b0;
                            lut_q   <= '0;
                            shift_q <= '0;
                            rep_q   <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            lut_q   <= lut_d;
                            shift_q <= lut_d[4:0];
                            rep_q   <= rep_d;
                            last_q  <= last_d;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load       = (state_q == IDLE) & start & ~abort & ~rst;
    assign iter_valid = valid_q;
    assign pre_sel    = pre_sel_q;
    assign lut_num    = lut_q;
    assign shift      = shift_q;
    assign rep        = rep_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pre_hyp_cordic_ctrl.sv
// Bench for pre_hyp_cordic_ctrl: default instance checked through a step
// scoreboard, a MAIN_ITER=12 instance checked against a vector table.
module tb_pre_hyp_cordic_ctrl;

    typedef struct packed {
        logic       pre_sel;
        logic [5:0] lut;
        logic [4:0] shift;
        logic       rep;
        logic       last;
    } vec_t;

    logic clk = 1'b0, rst, start, abort, iter_ready, start_b;
    logic load, iter_valid, pre_sel, rep, last, busy, done;
    logic [5:0] lut_num;
    logic [4:0] shift;
    logic load_b, iter_valid_b, pre_sel_b, rep_b, last_b, busy_b, done_b;
    logic [5:0] lut_num_b;
    logic [4:0] shift_b;

    always #5 clk = ~clk;

    pre_hyp_cordic_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .iter_ready(iter_ready),
        .load(load), .iter_valid(iter_valid), .pre_sel(pre_sel), .lut_num(lut_num),
        .shift(shift), .rep(rep), .last(last), .busy(busy), .done(done));

    pre_hyp_cordic_ctrl #(.PRE_ITER(6), .MAIN_ITER(12)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .iter_ready(iter_ready),
        .load(load_b), .iter_valid(iter_valid_b), .pre_sel(pre_sel_b), .lut_num(lut_num_b),
        .shift(shift_b), .rep(rep_b), .last(last_b), .busy(busy_b), .done(done_b));

    int n_vec = 0, n_bad = 0;
    int cyc = 0, load_cyc = 0, lat = 0, done_cnt = 0;
    vec_t q[$];
    vec_t qb[$];

    int main16[18] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16};
    int main12[13] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected issue order for one run, pushed when the run is launched.
    task automatic fill(input bit b12);
        vec_t v;
        int n, l, prev;
        n = b12 ? 13 : 18;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            v = '{1'b1, 6'(k), 5'(k + 2), 1'b0, 1'b0};
            if (b12) qb.push_back(v); else q.push_back(v);
        end
        for (int i = 0; i < n; i++) begin
            l = b12 ? main12[i] : main16[i];
            v = '{1'b0, 6'(l), 5'(l), (l == prev), (i == n - 1)};
            prev = l;
            if (b12) qb.push_back(v); else q.push_back(v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (load) load_cyc = cyc;
        if (done) begin
            done_cnt++;
            lat = cyc - load_cyc;
        end
        if (iter_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_step: got lut=%0d pre=%0d expected no step", lut_num, pre_sel);
            end else begin
                chk("step", 32'({pre_sel, lut_num, shift, rep, last}), 32'(q[0]));
                chk("busy_run", 32'(busy), 32'd1);
                if (iter_ready) void'(q.pop_front());
            end
        end
    end

    task automatic wait_step(input bit ps, input int ln, input string nm);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(iter_valid && pre_sel == ps && lut_num == 6'(ln)) && t < 100);
        if (t >= 100) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic outs_zero(input string nm);
        chk(nm, 32'({iter_valid, pre_sel, lut_num, shift, rep, last, busy, done}), 32'd0);
    endtask

    task automatic launch();
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); chk("load", 32'(load), 32'd1);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_full(input int exp_lat, input bit bp);
        int d0, t;
        d0 = done_cnt;
        fill(1'b0);
        launch();
        if (bp) begin
            wait_step(1'b1, 1, "bp");
            @(posedge clk); #1 iter_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 iter_ready = 1'b1;
        end
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("done_timeout", 32'd1, 32'd0);
        @(negedge clk);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("all_issued", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int d0, t;
        rst = 1'b1; start = 1'b1; abort = 1'b0; iter_ready = 1'b1; start_b = 1'b0;
        #3;
        chk("rst_load", 32'(load), 32'd0);
        outs_zero("rst_outs");
        chk("rst_outs_b", 32'({iter_valid_b, lut_num_b, shift_b, busy_b, done_b}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;

        run_full(25, 1'b0);
        run_full(28, 1'b1);

        // Abort in MAIN at index 7
        fill(1'b0);
        d0 = done_cnt;
        launch();
        wait_step(1'b0, 6, "abort");
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk); chk("abort_at7", 32'(lut_num), 32'd7);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk); outs_zero("abort_outs");
        q.delete();
        repeat (5) @(negedge clk);
        chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
        run_full(25, 1'b0);

        // start with abort in IDLE
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(negedge clk); chk("start_abort_load", 32'(load), 32'd0);
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk); outs_zero("start_abort_idle");

        // start pulses during MAIN and FIN are ignored
        fill(1'b0);
        d0 = done_cnt;
        launch();
        wait_step(1'b0, 8, "main_start");
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); chk("load_in_main", 32'(load), 32'd0);
        @(posedge clk); #1 start = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(iter_valid && last) && t < 100);
        if (t >= 100) chk("last_timeout", 32'd1, 32'd0);
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk);
        chk("load_in_fin", 32'(load), 32'd0);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("post_fin_busy", 32'(busy), 32'd0);
        chk("post_fin_valid", 32'(iter_valid), 32'd0);
        @(negedge clk);
        chk("fin_start_one_done", 32'(done_cnt - d0), 32'd1);
        chk("fin_queue", 32'(q.size()), 32'd0);

        // Async reset between edges in PRE at index 3
        fill(1'b0);
        d0 = done_cnt;
        launch();
        wait_step(1'b1, 2, "rst");
        @(posedge clk); #1;
        chk("pre_lut3", 32'(lut_num), 32'd3);
        #2 rst = 1'b1;
        #1;
        outs_zero("async_rst_outs");
        chk("async_rst_load", 32'(load), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        chk("rst_nodone", 32'(done_cnt - d0), 32'd0);
        run_full(25, 1'b0);

        // MAIN_ITER=12 instance, table applied in order
        fill(1'b1);
        @(posedge clk); #1 start_b = 1'b1;
        @(negedge clk); chk("b_load", 32'(load_b), 32'd1);
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            chk("b_valid", 32'(iter_valid_b), 32'd1);
            chk("b_step", 32'({pre_sel_b, lut_num_b, shift_b, rep_b, last_b}), 32'(qb[i]));
        end
        @(negedge clk);
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_fin_valid", 32'(iter_valid_b), 32'd0);
        @(negedge clk);
        chk("b_idle", 32'({busy_b, done_b}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
